// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational decode reads, commit-side writes/traps/mret, M-mode counters.
// Latency: reads 0 cycles; state updates and the fetch redirect are visible 1 cycle after the edge.
// Backpressure: none; every request and event is consumed on the cycle it is presented.
package common;
    typedef logic [63:0] word_t;

    typedef struct packed {
        logic        valid;
        logic        w_valid;
        logic [11:0] ra;
    } csr_input_t;

    typedef struct packed {
        word_t rd;
    } csr_output_t;
endpackage

module csr_file
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  csr_input_t  csr_input,
    output csr_output_t csr_output,
    input  logic        wr_valid,
    input  logic [11:0] wr_addr,
    input  word_t       wr_data,
    input  logic        commit_valid,
    input  logic        trap_valid,
    input  word_t       trap_pc,
    input  word_t       trap_cause,
    input  word_t       trap_tval,
    input  logic        mret_valid,
    output logic        redirect_valid,
    output word_t       redirect_pc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    // Only MIE[3], MPIE[7] and MPP[12:11] exist in mstatus.
    localparam word_t MSTATUS_MASK = 64'h0000_0000_0000_1888;

    word_t mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcycle, minstret;

    logic  wr_en;
    word_t wr_val;
    logic  unused_w_valid;

    assign unused_w_valid = csr_input.w_valid;

    function automatic logic is_impl(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC,
            A_MCAUSE, A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic word_t wr_mask(input logic [11:0] a, input word_t d);
        case (a)
            A_MSTATUS:      return d & MSTATUS_MASK;
            A_MTVEC, A_MEPC: return d & ~64'h3;
            default:        return d;
        endcase
    endfunction

    // A write shadowed by a trap or mret never lands, so it is not bypassed either.
    assign wr_en  = wr_valid & ~trap_valid & ~mret_valid;
    assign wr_val = wr_mask(wr_addr, wr_data);

    always_comb begin
        csr_output.rd = '0;
        if (csr_input.valid) begin
            if (wr_en && wr_addr == csr_input.ra && is_impl(csr_input.ra)) begin
                csr_output.rd = wr_val;
            end else begin
                case (csr_input.ra)
                    A_MSTATUS:  csr_output.rd = mstatus;
                    A_MIE:      csr_output.rd = mie;
                    A_MTVEC:    csr_output.rd = mtvec;
                    A_MSCRATCH: csr_output.rd = mscratch;
                    A_MEPC:     csr_output.rd = mepc;
                    A_MCAUSE:   csr_output.rd = mcause;
                    A_MTVAL:    csr_output.rd = mtval;
                    A_MIP:      csr_output.rd = mip;
                    A_MCYCLE:   csr_output.rd = mcycle;
                    A_MINSTRET: csr_output.rd = minstret;
                    default:    csr_output.rd = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus        <= '0;
            mie            <= '0;
            mtvec          <= '0;
            mscratch       <= '0;
            mepc           <= '0;
            mcause         <= '0;
            mtval          <= '0;
            mip            <= '0;
            mcycle         <= '0;
            minstret       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap_valid | mret_valid;
            mcycle         <= mcycle + 64'd1;
            if (!trap_valid) begin
                minstret <= minstret + {63'd0, commit_valid};
            end

            // Later assignments below override the counter defaults above.
            if (trap_valid) begin
                mepc        <= trap_pc & ~64'h3;
                mcause      <= trap_cause;
                mtval       <= trap_tval;
                mstatus     <= {51'd0, 2'b11, 3'd0, mstatus[3], 7'd0};
                redirect_pc <= mtvec;
            end else if (mret_valid) begin
                mstatus     <= {51'd0, 2'b11, 3'd0, 1'b1, 3'd0, mstatus[7], 3'd0};
                redirect_pc <= mepc;
            end else if (wr_valid) begin
                case (wr_addr)
                    A_MSTATUS:  mstatus  <= wr_val;
                    A_MIE:      mie      <= wr_val;
                    A_MTVEC:    mtvec    <= wr_val;
                    A_MSCRATCH: mscratch <= wr_val;
                    A_MEPC:     mepc     <= wr_val;
                    A_MCAUSE:   mcause   <= wr_val;
                    A_MTVAL:    mtval    <= wr_val;
                    A_MIP:      mip      <= wr_val;
                    A_MCYCLE:   mcycle   <= wr_val;
                    A_MINSTRET: minstret <= wr_val;
                    default:    ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against an associative-array model of the M-mode CSR set.
module tb_csr_file;
    import common::*;

    logic        clk = 1'b0;
    logic        reset;
    csr_input_t  csr_input;
    csr_output_t csr_output;
    logic        wr_valid;
    logic [11:0] wr_addr;
    word_t       wr_data;
    logic        commit_valid;
    logic        trap_valid;
    word_t       trap_pc, trap_cause, trap_tval;
    logic        mret_valid;
    logic        redirect_valid;
    word_t       redirect_pc;

    csr_file dut (
        .clk           (clk),
        .reset         (reset),
        .csr_input     (csr_input),
        .csr_output    (csr_output),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit_valid  (commit_valid),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .trap_cause    (trap_cause),
        .trap_tval     (trap_tval),
        .mret_valid    (mret_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    word_t       m [logic [11:0]];
    logic        m_rv;
    word_t       m_rpc;
    word_t       last_rd;
    logic        last_rv;
    word_t       last_rpc;
    logic [11:0] impl_addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                     12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t wmask(input logic [11:0] a, input word_t d);
        if (a == 12'h300) return d & 64'h1888;
        if (a == 12'h305 || a == 12'h341) return d & ~64'h3;
        return d;
    endfunction

    function automatic word_t model_rd();
        if (!csr_input.valid) return '0;
        if (!m.exists(csr_input.ra)) return '0;
        if (wr_valid && !trap_valid && !mret_valid && wr_addr == csr_input.ra)
            return wmask(wr_addr, wr_data);
        return m[csr_input.ra];
    endfunction

    task automatic model_reset();
        foreach (impl_addrs[i]) m[impl_addrs[i]] = '0;
        m_rv  = 1'b0;
        m_rpc = '0;
    endtask

    task automatic model_edge();
        word_t ms;
        if (reset) begin
            model_reset();
            return;
        end
        ms    = m[12'h300];
        m_rv  = trap_valid | mret_valid;
        m[12'hB00] = m[12'hB00] + 1;
        if (!trap_valid && commit_valid) m[12'hB02] = m[12'hB02] + 1;
        if (trap_valid) begin
            m_rpc      = m[12'h305];
            m[12'h341] = trap_pc & ~64'h3;
            m[12'h342] = trap_cause;
            m[12'h343] = trap_tval;
            m[12'h300] = 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
        end else if (mret_valid) begin
            m_rpc      = m[12'h341];
            m[12'h300] = 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
        end else if (wr_valid && m.exists(wr_addr)) begin
            m[wr_addr] = wmask(wr_addr, wr_data);
        end
    endtask

    task automatic idle(input logic [11:0] ra);
        csr_input    = '{valid: 1'b1, w_valid: 1'b0, ra: ra};
        wr_valid     = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        commit_valid = 1'b0;
        trap_valid   = 1'b0;
        trap_pc      = '0;
        trap_cause   = '0;
        trap_tval    = '0;
        mret_valid   = 1'b0;
    endtask

    task automatic do_cycle(input string tag);
        @(negedge clk);
        last_rd  = csr_output.rd;
        last_rv  = redirect_valid;
        last_rpc = redirect_pc;
        check({tag, ".rd"}, last_rd, model_rd());
        check({tag, ".rv"}, {63'd0, last_rv}, {63'd0, m_rv});
        check({tag, ".rpc"}, last_rpc, m_rpc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input word_t d);
        idle(a);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        do_cycle("wr");
    endtask

    initial begin
        reset = 1'b1;
        idle(12'h300);
        @(posedge clk);
        model_reset();
        #1;

        foreach (impl_addrs[i]) begin
            idle(impl_addrs[i]);
            do_cycle("reset");
        end
        check("reset.rd_const", last_rd, 64'd0);

        reset = 1'b0;
        idle(12'hB00);
        do_cycle("mcycle0");
        for (int i = 1; i <= 3; i++) begin
            do_cycle("mcycle");
            check("mcycle_seq", last_rd, word_t'(i));
        end

        idle(12'h305);
        wr_valid = 1'b1;
        wr_addr  = 12'h305;
        wr_data  = 64'h8000_0003;
        do_cycle("bypass");
        check("bypass_const", last_rd, 64'h8000_0000);
        idle(12'h305);
        do_cycle("mtvec_after");
        check("mtvec_const", last_rd, 64'h8000_0000);

        do_write(12'h305, 64'h8000_0100);
        do_write(12'h300, 64'h8);
        do_write(12'h340, 64'h1234);

        idle(12'h340);
        trap_valid = 1'b1;
        trap_pc    = 64'h8000_0010;
        trap_cause = 64'd2;
        trap_tval  = 64'h55;
        do_cycle("trap");
        idle(12'h341);
        do_cycle("post_trap");
        check("trap_rv", {63'd0, last_rv}, 64'd1);
        check("trap_rpc", last_rpc, 64'h8000_0100);
        check("trap_mepc", last_rd, 64'h8000_0010);
        idle(12'h342);
        do_cycle("mcause");
        check("trap_mcause", last_rd, 64'd2);
        check("trap_pulse", {63'd0, last_rv}, 64'd0);
        idle(12'h300);
        do_cycle("mstatus_trap");
        check("trap_mstatus", last_rd, 64'h1880);

        idle(12'h300);
        mret_valid = 1'b1;
        do_cycle("mret");
        idle(12'h300);
        do_cycle("post_mret");
        check("mret_rv", {63'd0, last_rv}, 64'd1);
        check("mret_rpc", last_rpc, 64'h8000_0010);
        check("mret_mstatus", last_rd, 64'h1888);
        idle(12'h300);
        do_cycle("mret_pulse");
        check("mret_pulse", {63'd0, last_rv}, 64'd0);

        idle(12'h340);
        trap_valid = 1'b1;
        mret_valid = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 12'h340;
        wr_data    = 64'hDEAD;
        trap_pc    = 64'h8000_0020;
        do_cycle("prio");
        idle(12'h340);
        do_cycle("prio_after");
        check("prio_mscratch", last_rd, 64'h1234);
        check("prio_rpc", last_rpc, 64'h8000_0100);

        idle(12'hB02);
        wr_valid     = 1'b1;
        wr_addr      = 12'hB02;
        wr_data      = '1;
        commit_valid = 1'b1;
        do_cycle("minstret_wr");
        idle(12'hB02);
        commit_valid = 1'b1;
        do_cycle("minstret_max");
        check("minstret_max", last_rd, '1);
        idle(12'hB02);
        do_cycle("minstret_wrap");
        check("minstret_wrap", last_rd, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [11:0] ra;
            ra = ($urandom_range(0, 4) == 0) ? 12'($urandom) : impl_addrs[$urandom_range(0, 9)];
            idle(ra);
            csr_input.valid = ($urandom_range(0, 7) != 0);
            reset           = ($urandom_range(0, 99) == 0);
            wr_valid        = ($urandom_range(0, 2) == 0);
            wr_addr         = ($urandom_range(0, 1) == 0) ? ra : impl_addrs[$urandom_range(0, 9)];
            wr_data         = {$urandom, $urandom};
            commit_valid    = $urandom_range(0, 1) == 1;
            trap_valid      = ($urandom_range(0, 15) == 0);
            mret_valid      = ($urandom_range(0, 15) == 0);
            trap_pc         = {$urandom, $urandom};
            trap_cause      = {$urandom, $urandom};
            trap_tval       = {$urandom, $urandom};
            do_cycle("rand");
        end

        reset = 1'b0;
        idle(12'h300);
        do_cycle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
